// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- direct-mapped, write-through / write-no-allocate data cache
// controller with flop-based storage (valid, tag and one 128-bit line per entry).
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   cpu_addr/re/we/din         core request (byte address, load, byte store enables, store data)
//   cpu_dout, stall            load data (held between loads), core freeze
//   mem_req_valid/ready/rw/addr        memory command channel (line address)
//   mem_req_data_valid/ready/bits/mask memory write-data channel
//   mem_resp_valid/data                memory read response (full line)
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          cpu_addr,
    input  logic                 cpu_re,
    input  logic [3:0]           cpu_we,
    input  logic [31:0]          cpu_din,
    output logic [31:0]          cpu_dout,
    output logic                 stall,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_rw,
    output logic [27:0]          mem_req_addr,
    output logic                 mem_req_data_valid,
    input  logic                 mem_req_data_ready,
    output logic [LINE_BITS-1:0] mem_req_data_bits,
    output logic [15:0]          mem_req_data_mask,
    input  logic                 mem_resp_valid,
    input  logic [LINE_BITS-1:0] mem_resp_data
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_DONE,
        WR_REQ,
        WR_DATA
    } state_t;

    state_t state;
    state_t state_next;

    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    // Latched request, so the core may drop its inputs after the sampling edge
    logic [27:0] req_line;
    logic [1:0]  req_off;
    logic [3:0]  req_we;
    logic [31:0] req_din;

    logic [IDX_W-1:0]     cpu_idx;
    logic [TAG_W-1:0]     cpu_tag;
    logic [1:0]           cpu_off;
    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic                 cpu_hit;
    logic                 take_store;
    logic                 take_hit;
    logic                 take_miss;
    logic                 fill;
    logic [LINE_BITS-1:0] store_line;
    logic                 unused_addr_bits;

    assign cpu_idx = cpu_addr[4 +: IDX_W];
    assign cpu_tag = cpu_addr[31 -: TAG_W];
    assign cpu_off = cpu_addr[3:2];
    assign req_idx = req_line[IDX_W-1:0];
    assign req_tag = req_line[27 -: TAG_W];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    // Requests are only accepted in IDLE; a store wins over a simultaneous load
    assign take_store = (state == IDLE) && (cpu_we != 4'b0000);
    assign take_hit   = (state == IDLE) && (cpu_we == 4'b0000) && cpu_re && cpu_hit;
    assign take_miss  = (state == IDLE) && (cpu_we == 4'b0000) && cpu_re && !cpu_hit;
    assign fill       = (state == RD_WAIT) && mem_resp_valid;

    assign mem_req_addr      = req_line;
    assign mem_req_data_bits = {4{req_din}};
    assign mem_req_data_mask = {12'b0, req_we} << {req_off, 2'b00};

    function automatic logic [31:0] word_sel(input logic [LINE_BITS-1:0] line,
                                             input logic [1:0] off);
        logic [31:0] w;
        w = line[31:0];
        case (off)
            2'd0: w = line[31:0];
            2'd1: w = line[63:32];
            2'd2: w = line[95:64];
            2'd3: w = line[127:96];
        endcase
        return w;
    endfunction

    // Cached line with the store's enabled bytes merged in (used on a store hit)
    always_comb begin
        store_line = data_q[cpu_idx];
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                if ((cpu_off == 2'(w)) && cpu_we[b]) begin
                    store_line[w*32 + b*8 +: 8] = cpu_din[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next         = state;
        stall              = 1'b1;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        case (state)
            IDLE: begin
                stall = 1'b0;
                if (take_store) begin
                    state_next = WR_REQ;
                end else if (take_miss) begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_resp_valid) begin
                    state_next = RD_DONE;
                end
            end
            RD_DONE: begin
                stall      = 1'b0;
                state_next = IDLE;
            end
            WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                if (mem_req_ready) begin
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                mem_req_data_valid = 1'b1;
                if (mem_req_data_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, valid bits and load data; a fill both completes the load
    // and validates the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            cpu_dout <= '0;
            req_line <= '0;
            req_off  <= '0;
            req_we   <= '0;
            req_din  <= '0;
        end else begin
            if (take_store || take_miss) begin
                req_line <= cpu_addr[31:4];
                req_off  <= cpu_off;
                req_we   <= cpu_we;
                req_din  <= cpu_din;
            end
            if (take_hit) begin
                cpu_dout <= word_sel(data_q[cpu_idx], cpu_off);
            end
            if (fill) begin
                valid_q[req_idx] <= 1'b1;
                cpu_dout         <= word_sel(mem_resp_data, req_off);
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q guards their contents.
    // A store miss leaves the arrays untouched (no allocation on write).
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[req_idx] <= mem_resp_data;
            tag_q[req_idx]  <= req_tag;
        end else if (take_store && cpu_hit) begin
            data_q[cpu_idx] <= store_line;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl -- self-checking bench for dcache_ctrl: table of core requests
// with expected load data / write masks, a memory responder that checks every
// command and write beat against scoreboard queues, plus backpressure and
// reset-abort sequences.
module tb_dcache_ctrl;

    typedef enum {K_LOAD_HIT, K_LOAD_MISS, K_STORE, K_NOP} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] addr;
        logic        re;
        logic [3:0]  we;
        logic [31:0] din;
        logic [15:0] expMask;
        logic [31:0] expDout;
    } vec_t;

    typedef struct packed {
        logic        rw;
        logic [27:0] line;
    } cmd_t;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  mask;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  cpu_addr;
    logic         cpu_re;
    logic [3:0]   cpu_we;
    logic [31:0]  cpu_din;
    logic [31:0]  cpu_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    int checkCount = 0;
    int errorCount = 0;

    cmd_t expCmdQ[$];
    wr_t  expWrQ[$];
    logic [31:0] expLoadQ[$];

    logic [127:0] memImage [logic [27:0]];

    int   reqDelay = 0;
    int   dataDelay = 0;
    bit   autoResp = 1;
    bit   forceResp = 0;
    int   rdCmds = 0;
    int   wrBeats = 0;

    vec_t vecs [17];

    dcache_ctrl #(.NUM_LINES(16), .LINE_BITS(128)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cpu_addr           (cpu_addr),
        .cpu_re             (cpu_re),
        .cpu_we             (cpu_we),
        .cpu_din            (cpu_din),
        .cpu_dout           (cpu_dout),
        .stall              (stall),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data)
    );

    initial forever #5 clk = ~clk;

    task automatic compare(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checkCount++;
        errorCount++;
        $display("[TB] FAIL %s", name);
    endtask

    function automatic vec_t mkVec(kind_e k, logic [31:0] a, logic re, logic [3:0] we,
                                   logic [31:0] din, logic [15:0] m, logic [31:0] d);
        vec_t v;
        v.kind = k; v.addr = a; v.re = re; v.we = we; v.din = din;
        v.expMask = m; v.expDout = d;
        return v;
    endfunction

    // Memory responder: checks commands and write beats against the scoreboard,
    // stretches ready by reqDelay/dataDelay cycles, returns read lines
    initial begin
        cmd_t         curCmd;
        wr_t          curWr;
        bit           cmdSeen;
        bit           dataSeen;
        bit           respPending;
        int           cmdWait;
        int           dataWait;
        logic [27:0]  respLine;
        logic [27:0]  wrLine;
        logic [127:0] ln;
        cmdSeen = 0; dataSeen = 0; respPending = 0; cmdWait = 0; dataWait = 0;
        respLine = '0; wrLine = '0; curCmd = '0; curWr = '0;
        mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        forever begin
            @(negedge clk);
            mem_req_ready = 0;
            mem_req_data_ready = 0;
            mem_resp_valid = 0;
            if (!rst_n) begin
                cmdSeen = 0; dataSeen = 0; respPending = 0;
            end else begin
                if (forceResp) begin
                    mem_resp_valid = 1;
                    mem_resp_data = {4{32'h0BAD0BAD}};
                    forceResp = 0;
                end
                if (respPending) begin
                    mem_resp_valid = 1;
                    mem_resp_data = memImage[respLine];
                    respPending = 0;
                end
                if (mem_req_valid) begin
                    if (!cmdSeen) begin
                        cmdSeen = 1;
                        cmdWait = 0;
                        if (expCmdQ.size() == 0) begin
                            failNow("unexpected memory command");
                            curCmd.rw = mem_req_rw;
                            curCmd.line = 28'h0;
                        end else begin
                            curCmd = expCmdQ.pop_front();
                        end
                    end
                    compare("cmd rw", mem_req_rw, curCmd.rw);
                    compare("cmd addr", mem_req_addr, curCmd.line);
                    compare("stall during cmd", stall, 1'b1);
                    if (cmdWait >= reqDelay) begin
                        mem_req_ready = 1;
                        cmdSeen = 0;
                        if (curCmd.rw) begin
                            wrLine = curCmd.line;
                        end else begin
                            rdCmds++;
                            if (autoResp) begin
                                respPending = 1;
                                respLine = curCmd.line;
                            end
                        end
                    end else begin
                        cmdWait++;
                    end
                end
                if (mem_req_data_valid) begin
                    if (!dataSeen) begin
                        dataSeen = 1;
                        dataWait = 0;
                        if (expWrQ.size() == 0) begin
                            failNow("unexpected write beat");
                            curWr = '0;
                        end else begin
                            curWr = expWrQ.pop_front();
                        end
                    end
                    compare("write data", mem_req_data_bits, curWr.data);
                    compare("write mask", mem_req_data_mask, curWr.mask);
                    compare("stall during write", stall, 1'b1);
                    if (dataWait >= dataDelay) begin
                        mem_req_data_ready = 1;
                        dataSeen = 0;
                        wrBeats++;
                        ln = memImage[wrLine];
                        for (int b = 0; b < 16; b++) begin
                            if (curWr.mask[b]) ln[b*8 +: 8] = curWr.data[b*8 +: 8];
                        end
                        memImage[wrLine] = ln;
                    end else begin
                        dataWait++;
                    end
                end
            end
        end
    end

    task automatic driveRequest(input logic [31:0] a, input logic re, input logic [3:0] we,
                                input logic [31:0] din);
        @(negedge clk);
        cpu_addr = a; cpu_re = re; cpu_we = we; cpu_din = din;
        @(posedge clk);
        #1;
        cpu_re = 0; cpu_we = 4'b0000;
        cpu_addr = 32'hFFFF_FFFC; cpu_din = 32'h5A5A_5A5A;
    endtask

    task automatic applyStimulus(input vec_t v);
        cmd_t c;
        wr_t  w;
        case (v.kind)
            K_LOAD_MISS: begin
                c.rw = 1'b0; c.line = v.addr[31:4];
                expCmdQ.push_back(c);
                expLoadQ.push_back(v.expDout);
            end
            K_LOAD_HIT: expLoadQ.push_back(v.expDout);
            K_STORE: begin
                c.rw = 1'b1; c.line = v.addr[31:4];
                expCmdQ.push_back(c);
                w.data = {4{v.din}}; w.mask = v.expMask;
                expWrQ.push_back(w);
            end
            default: ;
        endcase
        driveRequest(v.addr, v.re, v.we, v.din);
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        int n;
        logic [31:0] e;
        @(negedge clk);
        compare({tag, " stall T+1"}, stall, (v.kind == K_LOAD_MISS || v.kind == K_STORE));
        if (v.kind == K_LOAD_HIT || v.kind == K_NOP) begin
            compare({tag, " req valid"}, mem_req_valid, 1'b0);
            if (v.kind == K_LOAD_HIT && expLoadQ.size() > 0) begin
                e = expLoadQ.pop_front();
                compare({tag, " hit dout"}, cpu_dout, e);
            end else begin
                compare({tag, " held dout"}, cpu_dout, v.expDout);
            end
        end else begin
            n = 0;
            while (stall === 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (stall !== 1'b0) begin
                failNow({tag, " timeout waiting for stall low"});
            end else if (v.kind == K_LOAD_MISS && expLoadQ.size() > 0) begin
                e = expLoadQ.pop_front();
                compare({tag, " miss dout"}, cpu_dout, e);
            end else begin
                compare({tag, " held dout"}, cpu_dout, v.expDout);
            end
        end
    endtask

    initial begin
        int   n;
        int   r0;
        cmd_t c;
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   n;
        int   r0;
        cmd_t c;

        memImage[28'h10] = {32'hCAFE0003, 32'h12345678, 32'hDEADBEEF, 32'hCAFE0000};
        memImage[28'h20] = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
        memImage[28'h3F] = {32'h3F3F0003, 32'h3F3F0002, 32'h3F3F0001, 32'h3F3F0000};

        vecs[0]  = mkVec(K_LOAD_MISS, 32'h104, 1, 4'b0000, 32'h0,        16'h0,    32'hDEADBEEF);
        vecs[1]  = mkVec(K_LOAD_HIT,  32'h104, 1, 4'b0000, 32'h0,        16'h0,    32'hDEADBEEF);
        vecs[2]  = mkVec(K_LOAD_HIT,  32'h100, 1, 4'b0000, 32'h0,        16'h0,    32'hCAFE0000);
        vecs[3]  = mkVec(K_STORE,     32'h108, 0, 4'b0011, 32'h0000ABCD, 16'h0300, 32'hCAFE0000);
        vecs[4]  = mkVec(K_LOAD_HIT,  32'h108, 1, 4'b0000, 32'h0,        16'h0,    32'h1234ABCD);
        vecs[5]  = mkVec(K_STORE,     32'h200, 0, 4'b1111, 32'h11223344, 16'h000F, 32'h1234ABCD);
        vecs[6]  = mkVec(K_LOAD_MISS, 32'h200, 1, 4'b0000, 32'h0,        16'h0,    32'h11223344);
        vecs[7]  = mkVec(K_LOAD_MISS, 32'h100, 1, 4'b0000, 32'h0,        16'h0,    32'hCAFE0000);
        vecs[8]  = mkVec(K_LOAD_HIT,  32'h10C, 1, 4'b0000, 32'h0,        16'h0,    32'hCAFE0003);
        vecs[9]  = mkVec(K_STORE,     32'h104, 0, 4'b1100, 32'hBEEF0000, 16'h00C0, 32'hCAFE0003);
        vecs[10] = mkVec(K_LOAD_HIT,  32'h104, 1, 4'b0000, 32'h0,        16'h0,    32'hBEEFBEEF);
        vecs[11] = mkVec(K_NOP,       32'h300, 0, 4'b0000, 32'h0,        16'h0,    32'hBEEFBEEF);
        vecs[12] = mkVec(K_STORE,     32'h10C, 1, 4'b0001, 32'h000000AA, 16'h1000, 32'hBEEFBEEF);
        vecs[13] = mkVec(K_LOAD_HIT,  32'h10C, 1, 4'b0000, 32'h0,        16'h0,    32'hCAFE00AA);
        vecs[14] = mkVec(K_LOAD_MISS, 32'h3F4, 1, 4'b0000, 32'h0,        16'h0,    32'h3F3F0001);
        vecs[15] = mkVec(K_LOAD_HIT,  32'h3F8, 1, 4'b0000, 32'h0,        16'h0,    32'h3F3F0002);
        vecs[16] = mkVec(K_LOAD_HIT,  32'h108, 1, 4'b0000, 32'h0,        16'h0,    32'h1234ABCD);

        rst_n = 0;
        cpu_addr = '0; cpu_re = 0; cpu_we = 4'b0000; cpu_din = '0;
        repeat (3) @(negedge clk);
        compare("reset stall", stall, 1'b0);
        compare("reset req valid", mem_req_valid, 1'b0);
        compare("reset data valid", mem_req_data_valid, 1'b0);
        compare("reset dout", cpu_dout, 32'h0);
        #2 rst_n = 1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        $display("[TB] backpressure sequence");
        reqDelay = 5;
        dataDelay = 3;
        applyStimulus(mkVec(K_STORE, 32'h3F8, 0, 4'b1000, 32'h77000000, 16'h0800, 32'h1234ABCD));
        checkOutput(mkVec(K_STORE, 32'h3F8, 0, 4'b1000, 32'h77000000, 16'h0800, 32'h1234ABCD), "bp store");
        reqDelay = 0;
        dataDelay = 0;
        applyStimulus(mkVec(K_LOAD_HIT, 32'h3F8, 1, 4'b0000, 32'h0, 16'h0, 32'h773F0002));
        checkOutput(mkVec(K_LOAD_HIT, 32'h3F8, 1, 4'b0000, 32'h0, 16'h0, 32'h773F0002), "bp load");

        $display("[TB] reset during RD_WAIT sequence");
        autoResp = 0;
        c.rw = 1'b0; c.line = 28'h20;
        expCmdQ.push_back(c);
        r0 = rdCmds;
        driveRequest(32'h208, 1, 4'b0000, 32'h0);
        n = 0;
        while (rdCmds == r0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rdCmds == r0) failNow("abort read cmd never accepted");
        @(negedge clk);
        compare("abort stall in RD_WAIT", stall, 1'b1);
        compare("abort req valid in RD_WAIT", mem_req_valid, 1'b0);
        #2 rst_n = 0;
        #1;
        compare("abort stall in reset", stall, 1'b0);
        compare("abort dout in reset", cpu_dout, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        forceResp = 1;
        autoResp = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            compare($sformatf("post-abort stall c%0d", k), stall, 1'b0);
            compare($sformatf("post-abort req valid c%0d", k), mem_req_valid, 1'b0);
        end
        applyStimulus(mkVec(K_LOAD_MISS, 32'h208, 1, 4'b0000, 32'h0, 16'h0, 32'hA0000002));
        checkOutput(mkVec(K_LOAD_MISS, 32'h208, 1, 4'b0000, 32'h0, 16'h0, 32'hA0000002), "rst 0x208");
        applyStimulus(mkVec(K_LOAD_MISS, 32'h104, 1, 4'b0000, 32'h0, 16'h0, 32'hBEEFBEEF));
        checkOutput(mkVec(K_LOAD_MISS, 32'h104, 1, 4'b0000, 32'h0, 16'h0, 32'hBEEFBEEF), "rst 0x104");
        applyStimulus(mkVec(K_LOAD_MISS, 32'h3F8, 1, 4'b0000, 32'h0, 16'h0, 32'h773F0002));
        checkOutput(mkVec(K_LOAD_MISS, 32'h3F8, 1, 4'b0000, 32'h0, 16'h0, 32'h773F0002), "rst 0x3F8");

        repeat (2) @(negedge clk);
        compare("read commands total", rdCmds, 8);
        compare("write beats total", wrBeats, 5);
        compare("cmd queue drained", expCmdQ.size(), 0);
        compare("write queue drained", expWrQ.size(), 0);
        compare("load queue drained", expLoadQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
